fsub_pipe: RTL

- Pipelined single-precision subtractor for the cpuex23 FPU: computes res = x - y with the team's FPU arithmetic rules.
- Three register stages with a valid/ready handshake on both sides and a tag passed through alongside each operation.
- Sits between the FPU issue logic and the writeback arbiter; it complements the combinational adder so that long subtract paths can be pipelined.

---
 rtl/fpu_pkg.sv | 37 +++
 rtl/lzc.sv | 15 +
 rtl/fsub_pipe.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared float32 field layout, constants and pipeline payloads for the FPU datapaths.
package fpu_pkg;

  localparam int unsigned EXP_W           = 8;
  localparam int unsigned MAN_W           = 23;
  localparam logic [7:0]  EXP_MAX         = 8'hFF;
  localparam int unsigned FAR_SHIFT_LIMIT = 26;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float32_t;

  // Align-stage payload: bigger operand plus both possible views of the smaller one.
  typedef struct packed {
    logic             sign;         // sign of the bigger operand
    logic [EXP_W-1:0] exp;          // exponent of the bigger operand
    logic             close;        // effective subtract with d <= 1
    logic             eff_add;
    logic [MAN_W:0]   man_big;      // {1, m}
    logic [25:0]      far_small;    // smaller mantissa aligned to man_big with 2 extra bits
    logic             far_sticky;   // OR of everything shifted past far_small
    logic [MAN_W+1:0] close_small;  // smaller mantissa on the 25-bit close-path grid
  } s1_t;

  // Normalise-stage payload; exp is two's complement so underflow stays visible.
  typedef struct packed {
    logic             sign;
    logic [9:0]       exp;
    logic [MAN_W-1:0] man;
    logic             guard;
    logic             rest;         // round | sticky
    logic             zero;         // result is +0 (exact cancel or underflow)
  } s2_t;

endpackage

// File: rtl/lzc.sv
// 25-bit leading-zero counter; an all-zero input returns 25.
module lzc (
  input  logic [24:0] data_i,
  output logic [4:0]  cnt_o
);

  // Scan upwards so the most significant set bit decides the count.
  always_comb begin
    cnt_o = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (data_i[i]) cnt_o = 5'(24 - i);
    end
  end

endmodule

// File: rtl/fsub_pipe.sv
// Three-stage float32 subtractor (align, add/normalise, round) with valid/ready and a tag.
module fsub_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x,
  input  logic [31:0]      y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      res,
  output logic [TAG_W-1:0] out_tag
);

  logic en, accept;
  logic v1_q, v2_q, v3_q;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic [TAG_W-1:0] tag1_q, tag2_q;
  logic [31:0] res_d;

  // No bubble collapsing: the whole pipe advances or holds as one.
  assign en        = ~v3_q | out_ready;
  assign in_ready  = en;
  assign accept    = in_valid & in_ready;
  assign out_valid = v3_q;

  // ---------------- Stage 1: swap, exponent difference, far-path alignment
  float32_t fx, fy;
  logic        b_sign, x_big;
  logic [7:0]  d;
  logic [23:0] big_man, small_man;
  logic [49:0] fld;

  assign fx = x;
  assign fy = y;

  // Operate on x + (-y); ties in exponent keep x as the bigger operand.
  always_comb begin
    b_sign    = ~fy.sign;
    x_big     = (fx.exp >= fy.exp);
    d         = x_big ? (fx.exp - fy.exp) : (fy.exp - fx.exp);
    big_man   = x_big ? {1'b1, fx.man} : {1'b1, fy.man};
    small_man = x_big ? {1'b1, fy.man} : {1'b1, fx.man};
    fld       = {small_man, 26'd0} >> d;
    s1_d         = '0;
    s1_d.sign    = x_big ? fx.sign : b_sign;
    s1_d.exp     = x_big ? fx.exp : fy.exp;
    s1_d.eff_add = (fx.sign == b_sign);
    s1_d.close   = ~s1_d.eff_add & (d <= 8'd1);
    s1_d.man_big = big_man;
    if (d < 8'(FAR_SHIFT_LIMIT)) begin
      s1_d.far_small  = fld[49:24];
      s1_d.far_sticky = |fld[23:0];
    end else begin
      s1_d.far_small  = '0;
      s1_d.far_sticky = 1'b1;
    end
    s1_d.close_small = d[0] ? {1'b0, small_man} : {small_man, 1'b0};
  end

  // ---------------- Stage 2: add/subtract and normalise
  logic [25:0] cdiff;
  logic [24:0] mag, norm;
  logic [4:0]  lz;
  logic [9:0]  e_close, e_far;
  logic [27:0] fa, fb, fsum;

  // Close-path magnitude; only d == 0 can go negative.
  always_comb begin
    cdiff = {1'b0, s1_q.man_big, 1'b0} - {1'b0, s1_q.close_small};
    mag   = cdiff[25] ? (25'd0 - cdiff[24:0]) : cdiff[24:0];
  end

  lzc u_lzc (
    .data_i (mag),
    .cnt_o  (lz)
  );

  // Pick close or far result and produce mantissa, guard and rest bits.
  always_comb begin
    norm    = mag << lz;
    e_close = {2'b00, s1_q.exp} - {5'd0, lz};
    fa      = {1'b0, s1_q.man_big, 3'b000};
    fb      = {1'b0, s1_q.far_small, s1_q.far_sticky};
    fsum    = s1_q.eff_add ? (fa + fb) : (fa - fb);
    e_far   = {2'b00, s1_q.exp};
    s2_d    = '0;
    if (s1_q.close) begin
      s2_d.sign  = cdiff[25] ? ~s1_q.sign : s1_q.sign;
      s2_d.exp   = e_close;
      s2_d.man   = norm[23:1];
      s2_d.guard = norm[0];
      s2_d.rest  = 1'b0;
      s2_d.zero  = ~norm[24] | e_close[9] | (e_close == 10'd0);
    end else begin
      s2_d.sign = s1_q.sign;
      if (fsum[27]) begin
        e_far      = e_far + 10'd1;
        s2_d.man   = fsum[26:4];
        s2_d.guard = fsum[3];
        s2_d.rest  = |fsum[2:0];
      end else if (fsum[26]) begin
        s2_d.man   = fsum[25:3];
        s2_d.guard = fsum[2];
        s2_d.rest  = |fsum[1:0];
      end else begin
        // Far subtract with d >= 2 loses at most one leading bit.
        e_far      = e_far - 10'd1;
        s2_d.man   = fsum[24:2];
        s2_d.guard = fsum[1];
        s2_d.rest  = fsum[0];
      end
      s2_d.exp  = e_far;
      s2_d.zero = e_far[9] | (e_far == 10'd0);
    end
  end

  // ---------------- Stage 3: round to nearest even, overflow to inf
  logic        rup;
  logic [23:0] m24;
  logic [9:0]  e3;

  // Mantissa carry-out bumps the exponent and leaves the fraction at zero.
  always_comb begin
    rup = s2_q.guard & (s2_q.rest | s2_q.man[0]);
    m24 = {1'b0, s2_q.man} + {23'd0, rup};
    e3  = s2_q.exp + {9'd0, m24[23]};
    if (s2_q.zero) begin
      res_d = 32'd0;
    end else if (~e3[9] & (e3 > 10'd254)) begin
      res_d = {s2_q.sign, EXP_MAX, 23'd0};
    end else begin
      res_d = {s2_q.sign, e3[7:0], m24[22:0]};
    end
  end

  // Valid bits: flush beats advance; reset clears them asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (en) begin
      v1_q <= accept;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // Payload registers move with the pipe and hold during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      res     <= '0;
      out_tag <= '0;
    end else if (en) begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      tag1_q  <= in_tag;
      tag2_q  <= tag1_q;
      res     <= res_d;
      out_tag <= tag2_q;
    end
  end

endmodule
